spi_pwm_cfg_slave: RTL and testbench
====================================

# spi_pwm_cfg_slave

Multi-channel SPI configuration slave that sits directly upstream of the PWM channels. It decodes LSB-first SPI frames of one command byte plus a 40-bit payload, maintains a per-channel bank of clock-divider and duty-cycle registers, and returns the addressed channel's current contents on MISO. Each channel gets a commit toggle so its PWM can pick up new settings safely in the system clock domain.

## Interface
- DUTY_CYCLE_WIDTH, 8, duty field width per channel
- CLOCK_DIV_WIDTH, 32, clock-divider field width per channel
- NUM_CH, 4, number of channels (1..16)
- RESET_DIV, 32'hFFFF, reset value of every clock-divider register
- spi_sclk  in  1  SPI clock; the block clock (mode 0)
- rst  in  1  reset, asynchronous, active-low
- spi_cs  in  1  chip select, active-low; high asynchronously clears frame state only
- spi_mosi  in  1  serial data in, LSB first
- spi_miso  out  1  serial data out, LSB first
- cfg_clock_div  out  NUM_CH*CLOCK_DIV_WIDTH  channel c at [c*CLOCK_DIV_WIDTH +: CLOCK_DIV_WIDTH]
- cfg_duty  out  NUM_CH*DUTY_CYCLE_WIDTH  channel c at [c*DUTY_CYCLE_WIDTH +: DUTY_CYCLE_WIDTH]
- cfg_toggle  out  NUM_CH  flips once per committed write to that channel
- frame_err  out  1  sticky error flag

## Operation
- Reset state (rst low):
  - cfg_clock_div = RESET_DIV on all channels.
  - cfg_duty = 0; cfg_toggle = 0; frame_err = 0; spi_miso = 0.
  - Bit counter = 0; phase = CMD.
- Frame state comprises the bit counter, shift register, phase, latched command and MISO shifter.
  - Cleared asynchronously while spi_cs is high.
  - Configuration registers, cfg_toggle and frame_err are not affected by spi_cs.
- Phases, advanced by the bit counter k (1-based, incremented on each posedge with spi_cs low):
  - CMD (k = 1..8): command bits shifted in, LSB first.
  - PAYLOAD (k = 9..48): payload bits shifted in, LSB first.
  - DONE (k > 48): further bits are ignored, the counter saturates, and the first extra bit sets frame_err.
- Command byte fields:
  - [3:0] channel.
  - [5:4] reserved, must be 0.
  - [6] clr_err.
  - [7] write = 1, read = 0.
- Command decode occurs at k = 8. The command is invalid if channel >= NUM_CH or reserved != 0. An invalid command:
  - sets frame_err;
  - suppresses the commit;
  - forces MISO to 0 for the payload phase.
- clr_err on a valid command clears frame_err at k = 8. If the same frame later errors, the set wins.
- Payload layout matches the PWM channel:
  - bits [CLOCK_DIV_WIDTH-1:0] = clock divider;
  - the next DUTY_CYCLE_WIDTH bits = duty.
- Commit (valid write only) occurs at k = 48, using the full 40 bits including the bit sampled on that edge:
  - cfg_clock_div[ch] and cfg_duty[ch] load together, never partially;
  - cfg_toggle[ch] inverts on the same edge.
- Short frame (spi_cs rises before k = 48): no commit, no error, registers unchanged.
- Read and write frames both shift the addressed channel's pre-frame contents out on MISO during PAYLOAD.

## Timing
- Inputs are sampled on posedge spi_sclk.
- spi_miso changes only on negedge spi_sclk:
  - 0 during CMD;
  - payload bit j (0-based) is driven after negedge 8+j;
  - 0 after negedge 48.
- MISO load snapshot is taken at posedge 8, so a commit in the same frame does not alter the bits being shifted out.
- Command-to-decode latency: the decode takes effect on the posedge that samples bit 8.
- Commit latency: registers valid immediately after posedge 48. No sclk edge after that is required.
- Back-to-back frames: spi_cs must go high for at least one clearing interval. The next frame restarts at k = 1.
- cfg_toggle is a level change for downstream two-flop synchronisation. The downstream stage re-samples cfg_* after the synchronised toggle edge; the fields stay stable until the next commit to that channel.
- rst asserted mid-frame: immediate return to reset values; the partial frame is discarded.

## Test plan
- Reset values: after reset release, cfg_clock_div = 0000FFFF on every channel, cfg_duty = 0, cfg_toggle = 0, frame_err = 0, miso = 0.
- Valid write: command 0x82 (write, ch2), payload div = 0x12345678, duty = 0x40 -> ch2 = {0x12345678, 0x40} after posedge 48; cfg_toggle = 0100; other channels unchanged; MISO returns 0000FFFF, 00.
- Read back: command 0x02 -> MISO bits 0..39 = 0x12345678 then 0x40 LSB first; no register or toggle change.
- Short write: command 0x81 + 30 payload bits, then spi_cs high -> ch1 unchanged, cfg_toggle[1] unchanged, frame_err = 0.
- Error paths:
  - command 0x85 with NUM_CH = 4 -> no commit, MISO all zero, frame_err = 1;
  - then command 0x40 -> frame_err = 0 at posedge 8;
  - then 50-bit frame 0x80 -> commit to ch0 and frame_err = 1 at posedge 49.
- Reset mid-frame: rst low at k = 20 of a write to ch3, then a full write to ch3 -> only the second frame commits; cfg_toggle[3] flips exactly once.

Source files
------------

// File: rtl/spi_pwm_cfg_slave_if.sv
// rtl/spi_pwm_cfg_slave_if.sv - SPI bus bundle between the configuration master and spi_pwm_cfg_slave
//
// Signals:
//   spi_cs   - chip select, active-low, driven by the master
//   spi_mosi - serial data master->slave, LSB first
//   spi_miso - serial data slave->master, LSB first
// spi_sclk and rst stay plain ports on the slave.

interface spi_pwm_cfg_slave_if;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_cs,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_cs,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_pwm_cfg_slave.sv
// rtl/spi_pwm_cfg_slave.sv - SPI configuration slave holding per-channel PWM divider/duty registers
//
// Ports:
//   spi_sclk      - SPI clock, also the block clock (mode 0)
//   rst           - asynchronous active-low reset
//   bus           - SPI bus (spi_cs, spi_mosi in; spi_miso out)
//   cfg_clock_div - channel c divider at [c*CLOCK_DIV_WIDTH +: CLOCK_DIV_WIDTH]
//   cfg_duty      - channel c duty at [c*DUTY_CYCLE_WIDTH +: DUTY_CYCLE_WIDTH]
//   cfg_toggle    - per-channel level that flips on every committed write
//   frame_err     - sticky frame error flag
//
// Frame: 8 command bits then CLOCK_DIV_WIDTH+DUTY_CYCLE_WIDTH payload bits,
// all LSB first. Command: [3:0] channel, [5:4] reserved (0), [6] clr_err,
// [7] write.

module spi_pwm_cfg_slave #(
    parameter int                         DUTY_CYCLE_WIDTH = 8,
    parameter int                         CLOCK_DIV_WIDTH  = 32,
    parameter int                         NUM_CH           = 4,
    parameter logic [CLOCK_DIV_WIDTH-1:0] RESET_DIV        = 32'hFFFF
) (
    input  logic                                 spi_sclk,
    input  logic                                 rst,
    spi_pwm_cfg_slave_if.slave                   bus,
    output logic [NUM_CH*CLOCK_DIV_WIDTH-1:0]    cfg_clock_div,
    output logic [NUM_CH*DUTY_CYCLE_WIDTH-1:0]   cfg_duty,
    output logic [NUM_CH-1:0]                    cfg_toggle,
    output logic                                 frame_err
);

    localparam int PW   = CLOCK_DIV_WIDTH + DUTY_CYCLE_WIDTH;
    localparam int LAST = 8 + PW;
    localparam int CW   = $clog2(LAST + 2);

    // Counter value before the edge that samples the named bit (k = cnt_q + 1).
    localparam logic [CW-1:0] K_CMD_END = CW'(7);
    localparam logic [CW-1:0] K_PAY_END = CW'(LAST - 1);
    localparam logic [CW-1:0] K_OVR     = CW'(LAST);
    localparam logic [CW-1:0] K_SAT     = CW'(LAST + 1);
    localparam logic [CW-1:0] K_PAY_0   = CW'(8);

    localparam logic [1:0] PH_CMD     = 2'd0;
    localparam logic [1:0] PH_PAYLOAD = 2'd1;
    localparam logic [1:0] PH_DONE    = 2'd2;

    // Frame state: cleared by rst or by spi_cs high.
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [1:0]     phase_q,  phase_d;
    logic [6:0]     cmd_sr_q, cmd_sr_d;
    logic [PW-2:0]  pay_sr_q, pay_sr_d;
    logic           valid_q,  valid_d;
    logic           wr_q,     wr_d;
    logic [3:0]     ch_q,     ch_d;
    logic [PW-1:0]  snap_q,   snap_d;
    logic           miso_q;

    // Configuration state: cleared by rst only.
    logic [CLOCK_DIV_WIDTH-1:0]  div_q  [NUM_CH];
    logic [DUTY_CYCLE_WIDTH-1:0] duty_q [NUM_CH];
    logic [NUM_CH-1:0]           toggle_q;
    logic                        err_q;

    logic           frame_rst_n;
    logic [7:0]     cmd_full;
    logic [PW-1:0]  pay_full;
    logic           cmd_ok;
    logic [PW-1:0]  sel_word;
    logic           decode_ev;
    logic           commit_ev;
    logic           overrun_ev;
    logic [CW-1:0]  miso_idx;

    assign frame_rst_n = rst & ~bus.spi_cs;

    // Include the bit being sampled on this edge so decode and commit see whole fields.
    assign cmd_full = {bus.spi_mosi, cmd_sr_q};
    assign pay_full = {bus.spi_mosi, pay_sr_q};
    assign cmd_ok   = (int'(cmd_full[3:0]) < NUM_CH) && (cmd_full[5:4] == 2'b00);
    assign miso_idx = cnt_q - K_PAY_0;

    always_comb begin
        sel_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cmd_full[3:0] == 4'(c)) begin
                sel_word = {duty_q[c], div_q[c]};
            end
        end
    end

    always_comb begin
        cnt_d      = (cnt_q == K_SAT) ? cnt_q : cnt_q + CW'(1);
        phase_d    = phase_q;
        cmd_sr_d   = cmd_sr_q;
        pay_sr_d   = pay_sr_q;
        valid_d    = valid_q;
        wr_d       = wr_q;
        ch_d       = ch_q;
        snap_d     = snap_q;
        decode_ev  = 1'b0;
        commit_ev  = 1'b0;
        overrun_ev = 1'b0;
        case (phase_q)
            PH_CMD: begin
                cmd_sr_d = cmd_full[7:1];
                if (cnt_q == K_CMD_END) begin
                    decode_ev = 1'b1;
                    valid_d   = cmd_ok;
                    wr_d      = cmd_full[7];
                    ch_d      = cmd_full[3:0];
                    // Snapshot now so a commit later in this frame cannot alter MISO.
                    snap_d    = cmd_ok ? sel_word : '0;
                    phase_d   = PH_PAYLOAD;
                end
            end
            PH_PAYLOAD: begin
                pay_sr_d = pay_full[PW-1:1];
                if (cnt_q == K_PAY_END) begin
                    commit_ev = valid_q & wr_q;
                    phase_d   = PH_DONE;
                end
            end
            default: begin
                // Counter saturates one past K_OVR, so this fires once per frame.
                overrun_ev = (cnt_q == K_OVR);
            end
        endcase
    end

    always_ff @(posedge spi_sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            cnt_q    <= '0;
            phase_q  <= PH_CMD;
            cmd_sr_q <= '0;
            pay_sr_q <= '0;
            valid_q  <= 1'b0;
            wr_q     <= 1'b0;
            ch_q     <= '0;
            snap_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            cmd_sr_q <= cmd_sr_d;
            pay_sr_q <= pay_sr_d;
            valid_q  <= valid_d;
            wr_q     <= wr_d;
            ch_q     <= ch_d;
            snap_q   <= snap_d;
        end
    end

    always_ff @(posedge spi_sclk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c]  <= RESET_DIV;
                duty_q[c] <= '0;
            end
            toggle_q <= '0;
            err_q    <= 1'b0;
        end else if (!bus.spi_cs) begin
            if (decode_ev) begin
                if (!cmd_ok) begin
                    err_q <= 1'b1;
                end else if (cmd_full[6]) begin
                    err_q <= 1'b0;
                end
            end
            if (overrun_ev) begin
                err_q <= 1'b1;
            end
            if (commit_ev) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_q == 4'(c)) begin
                        div_q[c]    <= pay_full[CLOCK_DIV_WIDTH-1:0];
                        duty_q[c]   <= pay_full[PW-1:CLOCK_DIV_WIDTH];
                        toggle_q[c] <= ~toggle_q[c];
                    end
                end
            end
        end
    end

    // MISO updates on the falling edge; after negedge 8+j it carries payload bit j.
    always_ff @(negedge spi_sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            miso_q <= 1'b0;
        end else if (phase_q == PH_PAYLOAD) begin
            miso_q <= snap_q[miso_idx];
        end else begin
            miso_q <= 1'b0;
        end
    end

    assign bus.spi_miso = miso_q;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_out
            assign cfg_clock_div[g*CLOCK_DIV_WIDTH +: CLOCK_DIV_WIDTH]   = div_q[g];
            assign cfg_duty[g*DUTY_CYCLE_WIDTH +: DUTY_CYCLE_WIDTH]      = duty_q[g];
        end
    endgenerate

    assign cfg_toggle = toggle_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_spi_pwm_cfg_slave.sv
// tb/tb_spi_pwm_cfg_slave.sv - self-checking bench for spi_pwm_cfg_slave against a frame-level model

module tb_spi_pwm_cfg_slave;

    logic         sclk = 1'b0;
    logic         rst;
    logic [127:0] div_o;
    logic [31:0]  duty_o;
    logic [3:0]   tog_o;
    logic         err_o;

    always #5 sclk = ~sclk;

    spi_pwm_cfg_slave_if bus();

    spi_pwm_cfg_slave dut (
        .spi_sclk      (sclk),
        .rst           (rst),
        .bus           (bus),
        .cfg_clock_div (div_o),
        .cfg_duty      (duty_o),
        .cfg_toggle    (tog_o),
        .frame_err     (err_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: register bank as the master would see it.
    logic [31:0] m_div  [4];
    logic [7:0]  m_duty [4];
    logic [3:0]  m_tog;
    logic        m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_div[c]  = 32'h0000FFFF;
            m_duty[c] = 8'h00;
        end
        m_tog = 4'b0000;
        m_err = 1'b0;
    endtask

    task automatic check_cfg(input string tag);
        logic [31:0] ed;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s_div%0d", tag, c), 64'(div_o[c*32 +: 32]), 64'(m_div[c]));
            ed[c*8 +: 8] = m_duty[c];
        end
        chk($sformatf("%s_duty", tag), 64'(duty_o), 64'(ed));
        chk($sformatf("%s_tog", tag), 64'(tog_o), 64'(m_tog));
    endtask

    task automatic check_regs(input string tag);
        check_cfg(tag);
        chk($sformatf("%s_err", tag), 64'(err_o), 64'(m_err));
    endtask

    // Drives one frame of nbits bits; expectations come from the model before any bit is sent.
    task automatic frame(input string tag, input logic [7:0] cmd, input logic [39:0] pay,
                         input int nbits, input bit keep_cs);
        logic [47:0] stream;
        logic [1:0]  ch;
        bit          valid;
        logic [39:0] exp_snap;
        logic [39:0] got;
        logic [39:0] mask;
        logic        e8;
        int          zviol;

        stream   = {pay, cmd};
        ch       = cmd[1:0];
        valid    = (cmd[3:2] == 2'b00) && (cmd[5:4] == 2'b00);
        exp_snap = valid ? {m_duty[ch], m_div[ch]} : 40'd0;
        e8       = m_err;
        if (nbits >= 8) begin
            if (!valid)      e8 = 1'b1;
            else if (cmd[6]) e8 = 1'b0;
            m_err = e8;
        end
        if (nbits >= 48 && valid && cmd[7]) begin
            m_div[ch]  = pay[31:0];
            m_duty[ch] = pay[39:32];
            m_tog[ch]  = ~m_tog[ch];
        end
        if (nbits >= 49) m_err = 1'b1;

        got   = '0;
        mask  = '0;
        zviol = 0;
        @(negedge sclk); #1;
        bus.spi_cs = 1'b0;
        for (int k = 1; k <= nbits; k++) begin
            bus.spi_mosi = (k <= 48) ? stream[k-1] : 1'($urandom);
            @(posedge sclk); #1;
            if (k == 8)  chk({tag, "_err_k8"}, 64'(err_o), 64'(e8));
            if (k == 48) check_cfg({tag, "_k48"});
            if (k == 49) chk({tag, "_err_k49"}, 64'(err_o), 64'd1);
            @(negedge sclk); #1;
            if (k >= 8 && k <= 47) begin
                got[k-8]  = bus.spi_miso;
                mask[k-8] = 1'b1;
            end else if (bus.spi_miso !== 1'b0) begin
                zviol++;
            end
        end
        if (!keep_cs) bus.spi_cs = 1'b1;
        if (nbits >= 9) chk({tag, "_miso"}, 64'(got & mask), 64'(exp_snap & mask));
        chk({tag, "_miso_idle"}, 64'(zviol), 64'd0);
        if (!keep_cs) begin
            repeat (2) @(negedge sclk);
            #1;
            check_regs({tag, "_end"});
        end
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [39:0] pay;
        int          nb;

        rst          = 1'b0;
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        model_reset();
        repeat (3) @(negedge sclk);
        #1;
        check_regs("rst_hold");
        rst = 1'b1;
        repeat (2) @(negedge sclk);
        #1;
        check_regs("rst_rel");
        chk("rst_miso", 64'(bus.spi_miso), 64'd0);

        frame("wr_ch2",  8'h82, {8'h40, 32'h12345678}, 48, 1'b0);
        frame("rd_ch2",  8'h02, {8'($urandom), 32'($urandom)}, 48, 1'b0);
        frame("short1",  8'h81, {8'($urandom), 32'($urandom)}, 38, 1'b0);
        frame("bad_ch5", 8'h85, {8'($urandom), 32'($urandom)}, 48, 1'b0);
        frame("clr_err", 8'h40, {8'($urandom), 32'($urandom)}, 48, 1'b0);
        frame("long0",   8'h80, {8'hA5, 32'hCAFEF00D}, 50, 1'b0);

        // Reset in the middle of a write to ch3, then a complete write to ch3.
        frame("rst_mid", 8'h83, {8'h11, 32'h22334455}, 20, 1'b1);
        rst = 1'b0;
        #2;
        model_reset();
        check_regs("rst_mid_hold");
        chk("rst_mid_miso", 64'(bus.spi_miso), 64'd0);
        @(negedge sclk); #1;
        rst        = 1'b1;
        bus.spi_cs = 1'b1;
        repeat (2) @(negedge sclk);
        frame("wr_ch3", 8'h83, {8'h77, 32'h89ABCDEF}, 48, 1'b0);
        chk("tog3_once", 64'(tog_o[3]), 64'd1);

        for (int i = 0; i < 40; i++) begin
            cmd = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                cmd[5:4] = 2'b00;
                cmd[3:2] = 2'b00;
            end
            case ($urandom_range(0, 3))
                0:       nb = $urandom_range(49, 52);
                1:       nb = $urandom_range(4, 47);
                default: nb = 48;
            endcase
            pay = {8'($urandom), 32'($urandom)};
            frame($sformatf("rnd%0d", i), cmd, pay, nb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
